// File: rtl/pc_rx_pkg.sv
// Shared definitions for the PCIe RX command dispatcher: header magic,
// header field offsets (measured down from the word msb) and FSM states.
package pc_rx_pkg;

   localparam logic [7:0] HDR_MAGIC     = 8'hA5;

   // Each field's lsb sits at DATA_W - <OFS>; use as word[DATA_W-OFS +: width]
   localparam int         HDR_MAGIC_OFS = 8;
   localparam int         HDR_MAGIC_W   = 8;
   localparam int         HDR_CH_OFS    = 16;
   localparam int         HDR_CH_W      = 8;
   localparam int         HDR_LEN_OFS   = 32;
   localparam int         HDR_LEN_W     = 16;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PAYLOAD = 2'd1,
      ST_DRAIN   = 2'd2
   } state_t;

endpackage

// File: rtl/pc_rx_sat_cnt.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module pc_rx_sat_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_inc,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;

   // Count increments, sticking at the maximum value
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_cnt <= '0;
      else if (i_inc && (r_cnt != '1))
         r_cnt <= r_cnt + 1'b1;
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/pc_rx_cmd_dispatch.sv
// Pops header+payload packets from an FWFT FIFO and steers the payload
// to one of CH_NUM channels. Bad headers bump a saturating error count;
// packets aimed at a non-existent channel are drained and discarded.
module pc_rx_cmd_dispatch
   import pc_rx_pkg::*;
#(
   parameter int DATA_W = 128,
   parameter int CH_NUM = 4,
   parameter int ERR_W  = 16
) (
   input  logic              pcie_clk_250m,
   input  logic              rst,
   output logic              fifo_data_P2L_en,
   input  logic [DATA_W-1:0] fifo_data_P2L,
   input  logic              fifo_data_P2L_emp,
   output logic [CH_NUM-1:0] ch_valid,
   input  logic [CH_NUM-1:0] ch_ready,
   output logic [DATA_W-1:0] ch_data,
   output logic              ch_last,
   output logic [31:0]       pkt_cnt,
   output logic [ERR_W-1:0]  err_cnt
);

   localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;

   state_t                r_state;
   logic [HDR_LEN_W-1:0]  r_rem;
   logic [CH_W-1:0]       r_ch;
   logic [31:0]           r_pkt;

   logic [HDR_MAGIC_W-1:0] w_magic;
   logic [HDR_CH_W-1:0]    w_ch;
   logic [HDR_LEN_W-1:0]   w_len;
   logic                   w_magic_ok;
   logic                   w_ch_ok;
   logic [CH_NUM-1:0]      w_sel;
   logic                   w_sel_rdy;
   logic                   w_pop;
   logic                   w_err_inc;

   assign w_magic    = fifo_data_P2L[DATA_W-HDR_MAGIC_OFS +: HDR_MAGIC_W];
   assign w_ch       = fifo_data_P2L[DATA_W-HDR_CH_OFS    +: HDR_CH_W];
   assign w_len      = fifo_data_P2L[DATA_W-HDR_LEN_OFS   +: HDR_LEN_W];
   assign w_magic_ok = (w_magic == HDR_MAGIC);
   assign w_ch_ok    = (w_ch < HDR_CH_W'(CH_NUM));

   // One-hot decode of the latched channel; ready of other channels is masked off
   always_comb begin
      w_sel = '0;
      for (int i = 0; i < CH_NUM; i++)
         w_sel[i] = (r_ch == CH_W'(i));
   end

   assign w_sel_rdy = |(ch_ready & w_sel);

   // Pop strobe and channel-side outputs, all derived from the current state
   always_comb begin
      w_pop = 1'b0;
      unique case (r_state)
         ST_IDLE:    w_pop = ~fifo_data_P2L_emp;
         ST_PAYLOAD: w_pop = ~fifo_data_P2L_emp & w_sel_rdy;
         ST_DRAIN:   w_pop = ~fifo_data_P2L_emp;
         default:    w_pop = 1'b0;
      endcase
      fifo_data_P2L_en = w_pop & rst;
      ch_valid = (r_state == ST_PAYLOAD && !fifo_data_P2L_emp) ? w_sel : '0;
      ch_last  = (r_state == ST_PAYLOAD) && (r_rem == HDR_LEN_W'(1));
      ch_data  = (r_state == ST_PAYLOAD) ? fifo_data_P2L : '0;
   end

   // Header decode FSM: latch len/ch on the header pop, count down per payload pop
   always_ff @(posedge pcie_clk_250m or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
         r_rem   <= '0;
         r_ch    <= '0;
         r_pkt   <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_pop && w_magic_ok) begin
                  if (w_ch_ok) begin
                     if (w_len != '0) begin
                        r_state <= ST_PAYLOAD;
                        r_rem   <= w_len;
                        r_ch    <= w_ch[CH_W-1:0];
                     end else begin
                        r_pkt   <= r_pkt + 32'd1;
                     end
                  end else if (w_len != '0) begin
                     r_state <= ST_DRAIN;
                     r_rem   <= w_len;
                  end
               end
            end
            ST_PAYLOAD, ST_DRAIN: begin
               if (w_pop) begin
                  r_rem <= r_rem - 1'b1;
                  if (r_rem == HDR_LEN_W'(1)) begin
                     r_state <= ST_IDLE;
                     if (r_state == ST_PAYLOAD)
                        r_pkt <= r_pkt + 32'd1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // A header pop is an error when the magic is wrong or the channel does not exist
   assign w_err_inc = (r_state == ST_IDLE) && w_pop && (!w_magic_ok || !w_ch_ok);

   pc_rx_sat_cnt #(.W(ERR_W)) u_err_cnt (
      .clk   (pcie_clk_250m),
      .rst_n (rst),
      .i_inc (w_err_inc),
      .o_cnt (err_cnt)
   );

   assign pkt_cnt = r_pkt;

endmodule

// File: tb/tb_pc_rx_cmd_dispatch.sv
// Bench for pc_rx_cmd_dispatch: FWFT FIFO modelled as a queue, expected
// channel transfers derived by parsing the pushed word stream.
module tb_pc_rx_cmd_dispatch;

   localparam int DW  = 128;
   localparam int CHN = 4;
   localparam int EW  = 16;

   logic           clk = 1'b0;
   logic           rst;
   logic           fifo_en;
   logic [DW-1:0]  fifo_data;
   logic           emp;
   logic [CHN-1:0] ch_valid;
   logic [CHN-1:0] ch_ready;
   logic [DW-1:0]  ch_data;
   logic           ch_last;
   logic [31:0]    pkt_cnt;
   logic [EW-1:0]  err_cnt;

   always #5 clk = ~clk;

   pc_rx_cmd_dispatch #(.DATA_W(DW), .CH_NUM(CHN), .ERR_W(EW)) dut (
      .pcie_clk_250m     (clk),
      .rst               (rst),
      .fifo_data_P2L_en  (fifo_en),
      .fifo_data_P2L     (fifo_data),
      .fifo_data_P2L_emp (emp),
      .ch_valid          (ch_valid),
      .ch_ready          (ch_ready),
      .ch_data           (ch_data),
      .ch_last           (ch_last),
      .pkt_cnt           (pkt_cnt),
      .err_cnt           (err_cnt)
   );

   typedef struct {
      int          ch;
      logic [DW-1:0] data;
      logic        last;
   } xfer_t;

   logic [DW-1:0] q[$];
   logic [DW-1:0] stg[$];
   xfer_t         exp_q[$];

   int total = 0;
   int bad   = 0;
   int m_pkt = 0;
   int m_err = 0;
   int run_cyc, n_vld, n_xfer, rdy_mode;
   logic           p_hold;
   logic [CHN-1:0] p_valid;
   logic [DW-1:0]  p_data;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [DW-1:0] rnd_word();
      logic [DW-1:0] w;
      for (int k = 0; k < DW/32; k++) w[k*32 +: 32] = $urandom;
      return w;
   endfunction

   function automatic logic [DW-1:0] hdr(input logic [7:0] m, input logic [7:0] c, input logic [15:0] l);
      logic [DW-1:0] w;
      w = rnd_word();
      w[DW-1 -: 8]  = m;
      w[DW-9 -: 8]  = c;
      w[DW-17 -: 16] = l;
      return w;
   endfunction

   // Walk the staged words as a packet stream, record the expected results, queue them
   task automatic commit();
      int i;
      logic [7:0]  m, c;
      logic [15:0] l;
      i = 0;
      while (i < stg.size()) begin
         m = stg[i][DW-1 -: 8];
         c = stg[i][DW-9 -: 8];
         l = stg[i][DW-17 -: 16];
         i++;
         if (m != 8'hA5) m_err++;
         else if (c >= CHN) begin m_err++; i += int'(l); end
         else if (l == 0) m_pkt++;
         else begin
            for (int k = 0; k < int'(l); k++) begin
               exp_q.push_back('{int'(c), stg[i], (k == int'(l) - 1)});
               i++;
            end
            m_pkt++;
         end
      end
      foreach (stg[j]) q.push_back(stg[j]);
      stg.delete();
   endtask

   // One clock: present FIFO head, check channel outputs, apply pop at the edge
   task automatic cycle();
      logic [CHN-1:0] v;
      logic e, l, em;
      logic [DW-1:0] d;
      em = (q.size() == 0);
      emp = em;
      fifo_data = em ? rnd_word() : q[0];
      case (rdy_mode)
         0:       ch_ready = '1;
         1:       ch_ready = CHN'($urandom);
         default: ch_ready = (run_cyc >= 3 && run_cyc <= 5) ? 4'b1011 : 4'b1111;
      endcase
      #1;
      v = ch_valid; e = fifo_en; l = ch_last; d = ch_data;
      if (em) begin
         chk("en_when_emp", DW'(e), '0);
         chk("vld_when_emp", DW'(v), '0);
      end
      if (v != '0) begin
         n_vld++;
         chk("en_vs_rdy", DW'(e), DW'(|(v & ch_ready)));
         if (exp_q.size() == 0) chk("vld_spurious", DW'(v), '0);
         else begin
            chk("vld_chan", DW'(v), DW'(1) << exp_q[0].ch);
            if (e) begin
               chk("xfer_data", d, exp_q[0].data);
               chk("xfer_last", DW'(l), DW'(exp_q[0].last));
               void'(exp_q.pop_front());
               n_xfer++;
            end
         end
      end
      if (p_hold && !em) begin
         chk("hold_vld", DW'(v), DW'(p_valid));
         chk("hold_data", d, p_data);
      end
      p_hold = (v != '0) && !e;
      p_valid = v;
      p_data = d;
      @(posedge clk);
      if (e && q.size() > 0) void'(q.pop_front());
      #1;
   endtask

   task automatic run(input int max);
      run_cyc = 0;
      n_vld = 0;
      while ((q.size() > 0 || exp_q.size() > 0) && run_cyc < max) begin
         run_cyc++;
         cycle();
      end
      chk("drained", DW'(q.size() + exp_q.size()), '0);
   endtask

   initial begin
      rst = 1'b0;
      emp = 1'b0;
      fifo_data = hdr(8'hA5, 8'd1, 16'd3);
      ch_ready = '1;
      rdy_mode = 0;
      p_hold = 1'b0;
      n_xfer = 0;
      @(posedge clk);
      @(posedge clk);
      #2;
      chk("rst_en", DW'(fifo_en), '0);
      chk("rst_vld", DW'(ch_valid), '0);
      chk("rst_last", DW'(ch_last), '0);
      chk("rst_pkt", DW'(pkt_cnt), '0);
      chk("rst_err", DW'(err_cnt), '0);
      emp = 1'b1;
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Basic 3-word packet on channel 2, always ready
      stg.push_back(hdr(8'hA5, 8'd2, 16'd3));
      repeat (3) stg.push_back(rnd_word());
      commit();
      run(20);
      chk("t1_cycles", DW'(run_cyc), DW'(4));
      chk("t1_vld_cycles", DW'(n_vld), DW'(3));
      chk("t1_pkt", DW'(pkt_cnt), DW'(1));

      // Same packet, channel 2 stalls for payload cycles 2-4
      rdy_mode = 2;
      stg.push_back(hdr(8'hA5, 8'd2, 16'd3));
      repeat (3) stg.push_back(rnd_word());
      commit();
      run(30);
      chk("t2_cycles", DW'(run_cyc), DW'(7));
      chk("t2_vld_cycles", DW'(n_vld), DW'(6));
      chk("t2_pkt", DW'(pkt_cnt), DW'(2));

      // Bad magic: a single pop, next word is a header
      rdy_mode = 0;
      stg.push_back(hdr(8'h5A, 8'd2, 16'd3));
      stg.push_back(hdr(8'hA5, 8'd0, 16'd1));
      stg.push_back(rnd_word());
      commit();
      run(20);
      chk("t3_cycles", DW'(run_cyc), DW'(3));
      chk("t3_err", DW'(err_cnt), DW'(1));
      chk("t3_pkt", DW'(pkt_cnt), DW'(3));

      // Non-existent channel: payload drained, nothing presented
      stg.push_back(hdr(8'hA5, 8'd7, 16'd2));
      repeat (2) stg.push_back(rnd_word());
      commit();
      run(20);
      chk("t4_cycles", DW'(run_cyc), DW'(3));
      chk("t4_vld_cycles", DW'(n_vld), '0);
      chk("t4_err", DW'(err_cnt), DW'(2));
      chk("t4_pkt", DW'(pkt_cnt), DW'(3));

      // Zero-length packet then single-word packet, back to back
      stg.push_back(hdr(8'hA5, 8'd1, 16'd0));
      stg.push_back(hdr(8'hA5, 8'd0, 16'd1));
      stg.push_back(rnd_word());
      commit();
      run(20);
      chk("t5_cycles", DW'(run_cyc), DW'(3));
      chk("t5_pkt", DW'(pkt_cnt), DW'(5));

      // Random packet mix with random back-pressure
      rdy_mode = 1;
      for (int p = 0; p < 30; p++) begin
         logic [15:0] l;
         l = 16'($urandom_range(0, 6));
         if ($urandom_range(0, 7) == 0)
            stg.push_back(hdr(8'($urandom_range(0, 255)) ^ 8'h01 | 8'h00, 8'd0, 16'd0) ^ {8'h00, {(DW-8){1'b0}}});
         else begin
            stg.push_back(hdr(8'hA5, 8'($urandom_range(0, 5)), l));
            for (int k = 0; k < int'(l); k++) stg.push_back(rnd_word());
         end
      end
      commit();
      run(3000);
      chk("rnd_pkt", DW'(pkt_cnt), DW'(m_pkt));
      chk("rnd_err", DW'(err_cnt), DW'(m_err));

      // Reset in the middle of a 5-word packet
      rdy_mode = 0;
      n_xfer = 0;
      stg.push_back(hdr(8'hA5, 8'd1, 16'd5));
      repeat (5) stg.push_back(rnd_word());
      commit();
      run_cyc = 0;
      while (n_xfer < 2 && run_cyc < 20) begin
         run_cyc++;
         cycle();
      end
      chk("mid_xfers", DW'(n_xfer), DW'(2));
      rst = 1'b0;
      emp = 1'b0;
      fifo_data = q[0];
      #1;
      chk("mrst_en", DW'(fifo_en), '0);
      chk("mrst_vld", DW'(ch_valid), '0);
      chk("mrst_last", DW'(ch_last), '0);
      chk("mrst_data", ch_data, '0);
      chk("mrst_pkt", DW'(pkt_cnt), '0);
      chk("mrst_err", DW'(err_cnt), '0);
      @(posedge clk);
      #1;
      chk("mrst_en2", DW'(fifo_en), '0);
      q.delete();
      exp_q.delete();
      m_pkt = 0;
      m_err = 0;
      p_hold = 1'b0;
      emp = 1'b1;
      rst = 1'b1;
      stg.push_back(hdr(8'hA5, 8'd3, 16'd1));
      stg.push_back(rnd_word());
      commit();
      run(20);
      chk("post_rst_cycles", DW'(run_cyc), DW'(2));
      chk("post_rst_pkt", DW'(pkt_cnt), DW'(1));
      chk("post_rst_err", DW'(err_cnt), '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
